// File: rtl/helios_byte_io_controller_pkg.sv
// rtl/helios_byte_io_controller_pkg.sv - shared constants and state type for the host byte protocol
package helios_byte_io_controller_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;
  localparam int         RESULT_MSG_BYTES        = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HDR,
    RX_MEAS,
    RX_ERAS,
    DECODE,
    TX,
    GAP
  } io_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/helios_byte_io_controller_if.sv
// rtl/helios_byte_io_controller_if.sv - 8-bit valid/ready byte stream
interface helios_byte_io_controller_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/helios_result_tx.sv
// rtl/helios_result_tx.sv - latches the decode result and serializes it as 3 bytes
module helios_result_tx
  import helios_byte_io_controller_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic [7:0]                         iteration_count,
  input  logic [15:0]                        cycle_count,
  helios_byte_io_controller_if.master        out_bus,
  output logic                               done
);

  localparam logic [1:0] LAST_IDX = 2'(RESULT_MSG_BYTES - 1);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;
  logic        valid_q;
  logic        fire;

  assign out_bus.data  = shift_q[23:16];
  assign out_bus.valid = valid_q;
  assign fire          = valid_q && out_bus.ready;
  // Pulses on the final handshake so the owner can insert the end-of-message gap.
  assign done          = fire && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= {iteration_count, cycle_count};
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      shift_q <= {shift_q[15:0], 8'h00};
      if (idx_q == LAST_IDX) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/helios_byte_io_controller.sv
// rtl/helios_byte_io_controller.sv - frame parser, deserializer and result return path for the Helios core
module helios_byte_io_controller
  import helios_byte_io_controller_pkg::*;
#(
  parameter  int GRID_WIDTH_X    = 20,
  parameter  int GRID_WIDTH_Z    = 10,
  parameter  int GRID_WIDTH_U    = 19,
  parameter  int ERASURE_BYTES   = 39,
  localparam int BYTES_PER_ROUND = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) >> 3,
  localparam int MEAS_BYTES      = BYTES_PER_ROUND * GRID_WIDTH_U,
  localparam int ERAS_W          = max2(ERASURE_BYTES, 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  helios_byte_io_controller_if.slave    in_bus,
  helios_byte_io_controller_if.master   out_bus,
  output logic [MEAS_BYTES*8-1:0]       measurements,
  output logic [ERAS_W*8-1:0]           erasure,
  output logic                          start_decode,
  input  logic                          decode_done,
  input  logic [7:0]                    iteration_count,
  input  logic [15:0]                   cycle_count
);

  localparam int CNT_W = $clog2(max2(max2(MEAS_BYTES, ERASURE_BYTES), 2) + 1);
  localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_BYTES - 1);
  localparam logic [CNT_W-1:0] ERAS_LAST = CNT_W'((ERASURE_BYTES > 0) ? ERASURE_BYTES - 1 : 0);

  io_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             in_fire;
  logic             tx_load;
  logic             tx_done;

  assign in_bus.ready = ready_q;
  assign in_fire      = in_bus.valid && ready_q;
  assign tx_load      = (state_q == DECODE) && decode_done;

  helios_result_tx u_result_tx (
    .clk             (clk),
    .reset           (reset),
    .load            (tx_load),
    .iteration_count (iteration_count),
    .cycle_count     (cycle_count),
    .out_bus         (out_bus),
    .done            (tx_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      start_decode <= 1'b0;
      measurements <= '0;
      erasure      <= '0;
    end else begin
      start_decode <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (in_fire && in_bus.data == START_DECODING_MSG) state_q <= WAIT_HDR;
        end
        WAIT_HDR: begin
          ready_q <= 1'b1;
          if (in_fire && in_bus.data == MEASUREMENT_DATA_HEADER) begin
            state_q <= RX_MEAS;
            cnt_q   <= '0;
          end
        end
        RX_MEAS: begin
          if (in_fire) begin
            for (int k = 0; k < MEAS_BYTES; k++) begin
              if (cnt_q == CNT_W'(k)) measurements[8*k +: 8] <= in_bus.data;
            end
            if (cnt_q == MEAS_LAST) begin
              cnt_q <= '0;
              if (ERASURE_BYTES == 0) begin
                state_q      <= DECODE;
                ready_q      <= 1'b0;
                start_decode <= 1'b1;
              end else begin
                state_q <= RX_ERAS;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RX_ERAS: begin
          if (in_fire) begin
            for (int k = 0; k < ERASURE_BYTES; k++) begin
              if (cnt_q == CNT_W'(k)) erasure[8*k +: 8] <= in_bus.data;
            end
            if (cnt_q == ERAS_LAST) begin
              cnt_q        <= '0;
              state_q      <= DECODE;
              ready_q      <= 1'b0;
              start_decode <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DECODE: begin
          if (decode_done) state_q <= TX;
        end
        TX: begin
          if (tx_done) state_q <= GAP;
        end
        GAP: begin
          // Next frame reuses the session: no START needed, go straight to header wait.
          state_q <= WAIT_HDR;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_helios_byte_io_controller.sv
// tb/tb_helios_byte_io_controller.sv - directed bench for helios_byte_io_controller
module tb_helios_byte_io_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] meas_a, meas_b;
  logic [15:0] eras_a;
  logic [7:0]  eras_b;
  logic        start_a, start_b;
  logic        done_a, done_b;
  logic [7:0]  iter_a, iter_b;
  logic [15:0] cyc_a, cyc_b;
  int          checks = 0;
  int          errors = 0;
  int          xfers_a = 0;
  int          x0;

  always #5 clk = ~clk;

  helios_byte_io_controller_if in_a ();
  helios_byte_io_controller_if out_a ();
  helios_byte_io_controller_if in_b ();
  helios_byte_io_controller_if out_b ();

  helios_byte_io_controller #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(3), .ERASURE_BYTES(2)
  ) dut (
    .clk(clk), .reset(reset), .in_bus(in_a), .out_bus(out_a),
    .measurements(meas_a), .erasure(eras_a), .start_decode(start_a),
    .decode_done(done_a), .iteration_count(iter_a), .cycle_count(cyc_a)
  );

  helios_byte_io_controller #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(3), .ERASURE_BYTES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .in_bus(in_b), .out_bus(out_b),
    .measurements(meas_b), .erasure(eras_b), .start_decode(start_b),
    .decode_done(done_b), .iteration_count(iter_b), .cycle_count(cyc_b)
  );

  always @(posedge clk) if (out_a.valid && out_a.ready) xfers_a <= xfers_a + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    int n = 0;
    in_a.valid = 1'b1;
    in_a.data  = b;
    while (!in_a.ready && n < 50) begin tick(); n++; end
    chk("send_a_ready", {31'd0, in_a.ready}, 32'd1);
    tick();
    in_a.valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    int n = 0;
    in_b.valid = 1'b1;
    in_b.data  = b;
    while (!in_b.ready && n < 50) begin tick(); n++; end
    chk("send_b_ready", {31'd0, in_b.ready}, 32'd1);
    tick();
    in_b.valid = 1'b0;
  endtask

  task automatic result_a(input logic [7:0] it, input logic [15:0] cy);
    done_a = 1'b1; iter_a = it; cyc_a = cy; out_a.ready = 1'b1;
    tick();
    done_a = 1'b0;
    chk("start_one_cycle", {31'd0, start_a}, 32'd0);
    chk("tx_valid0", {31'd0, out_a.valid}, 32'd1);
    chk("tx_byte0", {24'd0, out_a.data}, {24'd0, it});
    tick();
    chk("tx_byte1", {24'd0, out_a.data}, {24'd0, cy[15:8]});
    tick();
    chk("tx_byte2", {24'd0, out_a.data}, {24'd0, cy[7:0]});
    tick();
    chk("gap_valid", {31'd0, out_a.valid}, 32'd0);
    chk("gap_in_ready", {31'd0, in_a.ready}, 32'd0);
    tick();
    chk("post_gap_ready", {31'd0, in_a.ready}, 32'd1);
    out_a.ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_a.valid = 1'b0; in_a.data = 8'h00; out_a.ready = 1'b0;
    in_b.valid = 1'b0; in_b.data = 8'h00; out_b.ready = 1'b0;
    done_a = 1'b0; iter_a = 8'h00; cyc_a = 16'h0000;
    done_b = 1'b0; iter_b = 8'h00; cyc_b = 16'h0000;

    // Reset state
    tick(); tick(); tick();
    chk("rst_in_ready", {31'd0, in_a.ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_a.valid}, 32'd0);
    chk("rst_start", {31'd0, start_a}, 32'd0);
    chk("rst_meas", {8'd0, meas_a}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_in_ready", {31'd0, in_a.ready}, 32'd1);

    // Back-to-back frame, result with no backpressure
    send_a(8'h01); send_a(8'h02); send_a(8'hA5); send_a(8'h3C);
    send_a(8'h0F); send_a(8'h11);
    chk("start_early", {31'd0, start_a}, 32'd0);
    send_a(8'h22);
    chk("start_pulse", {31'd0, start_a}, 32'd1);
    chk("decode_in_ready", {31'd0, in_a.ready}, 32'd0);
    chk("meas_f1", {8'd0, meas_a}, 32'h000F3CA5);
    chk("eras_f1", {16'd0, eras_a}, 32'h00002211);
    result_a(8'h07, 16'h1234);

    // Second frame without START, backpressured result
    send_a(8'h02); send_a(8'h11); send_a(8'h22); send_a(8'h33);
    send_a(8'h44); send_a(8'h55);
    chk("start_f2", {31'd0, start_a}, 32'd1);
    chk("meas_f2", {8'd0, meas_a}, 32'h00332211);
    chk("eras_f2", {16'd0, eras_a}, 32'h00005544);
    tick();
    chk("start_f2_off", {31'd0, start_a}, 32'd0);
    tick();
    chk("decode_wait_ready", {31'd0, in_a.ready}, 32'd0);
    chk("decode_wait_valid", {31'd0, out_a.valid}, 32'd0);
    x0 = xfers_a;
    done_a = 1'b1; iter_a = 8'hA0; cyc_a = 16'hBEEF;
    tick();
    done_a = 1'b0;
    chk("bp_valid", {31'd0, out_a.valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold0", {24'd0, out_a.data}, 32'h000000A0);
      done_a = (i == 1);
      tick();
    end
    done_a = 1'b0;
    out_a.ready = 1'b1; tick(); out_a.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold1", {24'd0, out_a.data}, 32'h000000BE);
      chk("bp_valid1", {31'd0, out_a.valid}, 32'd1);
      tick();
    end
    out_a.ready = 1'b1; tick(); out_a.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold2", {24'd0, out_a.data}, 32'h000000EF);
      tick();
    end
    out_a.ready = 1'b1; tick(); out_a.ready = 1'b0;
    chk("bp_gap", {31'd0, out_a.valid}, 32'd0);
    chk("bp_xfers", xfers_a - x0, 32'd3);
    tick();
    chk("bp_wait_hdr", {31'd0, in_a.ready}, 32'd1);
    tick();
    chk("bp_no_retx", {31'd0, out_a.valid}, 32'd0);

    // Garbage, repeated START, input gaps
    reset = 1'b1; tick(); reset = 1'b0; tick();
    send_a(8'hFF); send_a(8'h03); send_a(8'h01); send_a(8'h01); send_a(8'h02);
    send_a(8'hA1);
    tick();
    chk("gap_hold_ready", {31'd0, in_a.ready}, 32'd1);
    send_a(8'hB2); send_a(8'hC3);
    tick(); tick();
    chk("gap_no_start", {31'd0, start_a}, 32'd0);
    send_a(8'hD4); send_a(8'hE5);
    chk("gap_start", {31'd0, start_a}, 32'd1);
    chk("gap_meas", {8'd0, meas_a}, 32'h00C3B2A1);
    chk("gap_eras", {16'd0, eras_a}, 32'h0000E5D4);
    result_a(8'h01, 16'h0203);
    send_a(8'h02); send_a(8'h10); send_a(8'h20); send_a(8'h30);
    send_a(8'h40); send_a(8'h50);
    chk("nostart_start", {31'd0, start_a}, 32'd1);
    chk("nostart_meas", {8'd0, meas_a}, 32'h00302010);
    chk("nostart_eras", {16'd0, eras_a}, 32'h00005040);
    result_a(8'h3C, 16'h00FF);

    // Abort mid-frame by reset
    send_a(8'h02); send_a(8'h77); send_a(8'h88);
    chk("partial_meas", {8'd0, meas_a}, 32'h00308877);
    reset = 1'b1;
    tick();
    chk("abort_ready", {31'd0, in_a.ready}, 32'd0);
    chk("abort_meas", {8'd0, meas_a}, 32'd0);
    reset = 1'b0;
    tick();
    send_a(8'h02); send_a(8'h99); send_a(8'h99); send_a(8'h99);
    chk("idle_drop_meas", {8'd0, meas_a}, 32'd0);
    chk("idle_drop_start", {31'd0, start_a}, 32'd0);
    send_a(8'h01); send_a(8'h02); send_a(8'h5A); send_a(8'h6B); send_a(8'h7C);
    send_a(8'h8D); send_a(8'h9E);
    chk("fresh_start", {31'd0, start_a}, 32'd1);
    chk("fresh_meas", {8'd0, meas_a}, 32'h007C6B5A);
    chk("fresh_eras", {16'd0, eras_a}, 32'h00009E8D);

    // Build without erasure phase
    send_b(8'h01); send_b(8'h02); send_b(8'hAA); send_b(8'hBB);
    chk("ne_start_early", {31'd0, start_b}, 32'd0);
    send_b(8'hCC);
    chk("ne_start", {31'd0, start_b}, 32'd1);
    chk("ne_ready", {31'd0, in_b.ready}, 32'd0);
    chk("ne_meas", {8'd0, meas_b}, 32'h00CCBBAA);
    chk("ne_eras", {24'd0, eras_b}, 32'd0);
    done_b = 1'b1; iter_b = 8'h55; cyc_b = 16'h6677; out_b.ready = 1'b1;
    tick();
    done_b = 1'b0;
    chk("ne_start_off", {31'd0, start_b}, 32'd0);
    chk("ne_tx0", {24'd0, out_b.data}, 32'h00000055);
    tick();
    chk("ne_tx1", {24'd0, out_b.data}, 32'h00000066);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
